mips_fetch_unit: RTL and testbench



---
 rtl/mips_fetch_unit_if.sv | 53 +++++
 rtl/mips_fetch_unit.sv | 94 +++++++++
 tb/tb_mips_fetch_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, EX redirect/halt
// controls and the decode-side valid/ready instruction stream.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_npc;
  logic [CW-1:0]     fifo_count;

  modport master (
    output imem_rd_en,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_ir,
    output out_pc,
    output out_npc,
    output fifo_count
  );

  modport slave (
    input  imem_rd_en,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_ir,
    input  out_pc,
    input  out_npc,
    input  fifo_count
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch: PC, single outstanding imem read,
// prefetch FIFO of {ir, pc, npc} toward decode, redirect flush.
module mips_fetch_unit #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input logic             clk,
  input logic             rst,
  mips_fetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC0  = ADDR_W'(RESET_PC);
  localparam logic [CW:0]       FULL = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_fl;
  logic [ADDR_W-1:0] r_fl_pc;

  logic [31:0]       r_ir   [DEPTH];
  logic [ADDR_W-1:0] r_epc  [DEPTH];
  logic [ADDR_W-1:0] r_enpc [DEPTH];
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_cnt;

  logic              w_flush;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CW:0]       w_occ;

  // the returning read holds a slot; a same-cycle pop is not credited
  assign w_occ   = {1'b0, r_cnt} + {{CW{1'b0}}, r_fl};
  assign w_flush = bus.redirect_valid;
  assign w_valid = (r_cnt != '0);

  assign w_issue = !rst && !bus.halt && !w_flush
                 && (w_occ < FULL);
  assign w_push  = !rst && r_fl && !w_flush;
  assign w_pop   = w_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= PC0;
      r_fl    <= 1'b0;
      r_fl_pc <= PC0;
    end else begin
      r_fl <= w_issue;
      if (w_issue) r_fl_pc <= r_pc;
      if (w_flush) r_pc <= bus.redirect_pc;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case (1'b1)
        w_push && !w_pop: r_cnt <= r_cnt + CW'(1);
        w_pop && !w_push: r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ir[r_wr]   <= bus.imem_rdata;
      r_epc[r_wr]  <= r_fl_pc;
      r_enpc[r_wr] <= r_fl_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_pop)
      assert (r_cnt != CW'(DEPTH));
  end

  assign bus.imem_rd_en = w_issue;
  assign bus.imem_addr  = r_pc;
  assign bus.out_valid  = w_valid;
  assign bus.out_ir     = w_valid ? r_ir[r_rd]   : '0;
  assign bus.out_pc     = w_valid ? r_epc[r_rd]  : '0;
  assign bus.out_npc    = w_valid ? r_enpc[r_rd] : '0;
  assign bus.fifo_count = r_cnt;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomised and directed bench for mips_fetch_unit against a
// queue-based transaction model of the fetch front end.
module tb_mips_fetch_unit;
  typedef struct packed {
    logic [31:0] ir;
    logic [9:0]  pc;
  } ent_t;

  logic clk;
  logic rst;
  logic rst2;
  int   n_vec;
  int   n_err;

  ent_t        q[$];
  logic [9:0]  m_pc;
  logic        m_fl;
  logic [9:0]  m_fl_pc;

  mips_fetch_unit_if #(.ADDR_W(10), .DEPTH(4)) bus ();
  mips_fetch_unit_if #(.ADDR_W(10), .DEPTH(4)) bus2 ();

  mips_fetch_unit #(.ADDR_W(10), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mips_fetch_unit #(.ADDR_W(10), .DEPTH(4), .RESET_PC(1022)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [9:0] a);
    return 32'h1000_0000 + {22'b0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= memf(bus.imem_addr);
    if (bus2.imem_rd_en) bus2.imem_rdata <= memf(bus2.imem_addr);
  end

  function automatic logic [66:0] act_vec();
    return {bus.imem_rd_en, bus.imem_addr, bus.out_valid,
            bus.fifo_count, bus.out_ir, bus.out_pc, bus.out_npc};
  endfunction

  function automatic logic [66:0] exp_vec();
    logic iss;
    logic v;
    ent_t h;
    v = (q.size() != 0);
    h = v ? q[0] : '0;
    iss = !rst && !bus.halt && !bus.redirect_valid
        && (q.size() + int'(m_fl) < 4);
    return {iss, m_pc, v, 3'(q.size()), h.ir, h.pc,
            v ? h.pc + 10'd1 : 10'd0};
  endfunction

  task automatic set_in(input logic rdy, input logic hlt,
                        input logic rv, input logic [9:0] rpc);
    bus.out_ready      = rdy;
    bus.halt           = hlt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic tick();
    logic iss;
    if (rst) begin
      q.delete();
      m_pc = 10'd0;
      m_fl = 1'b0;
    end else begin
      iss = !bus.halt && !bus.redirect_valid
          && (q.size() + int'(m_fl) < 4);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (bus.redirect_valid) begin
        q.delete();
        m_fl = 1'b0;
        m_pc = bus.redirect_pc;
      end else begin
        if (m_fl) q.push_back('{ir: memf(m_fl_pc), pc: m_fl_pc});
        m_fl = iss;
        if (iss) begin
          m_fl_pc = m_pc;
          m_pc = m_pc + 10'd1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 10'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 10'd0);
    tick();
    #1;
    n_vec++;
    if (act_vec() !== 67'd0) begin
      n_err++;
      $display("FAIL reset_state got %h want 0", act_vec());
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_exit c%0d got %h want %h",
                 i, act_vec(), exp_vec());
      end
      n_vec++;
      if (i == 2 && {bus.out_valid, bus.out_ir, bus.out_pc, bus.out_npc}
          !== {1'b1, 32'h1000_0000, 10'd0, 10'd1}) begin
        n_err++;
        $display("FAIL first_valid got v%b ir%h pc%0d npc%0d want 1 10000000 0 1",
                 bus.out_valid, bus.out_ir, bus.out_pc, bus.out_npc);
      end else if (i < 2 && bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL early_valid c%0d got %b want 0", i, bus.out_valid);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL stream c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i >= 2) begin
        n_vec++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 10'(i - 2)}) begin
          n_err++;
          $display("FAIL stream_gap c%0d got v%b pc%0d want 1 %0d",
                   i, bus.out_valid, bus.out_pc, i - 2);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL stall c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 2) held = bus.out_ir;
      tick();
    end
    #1;
    n_vec++;
    if ({bus.fifo_count, bus.imem_rd_en, bus.out_ir}
        !== {3'd4, 1'b0, held}) begin
      n_err++;
      $display("FAIL stall_full got cnt%0d rd%b ir%h want 4 0 %h",
               bus.fifo_count, bus.imem_rd_en, bus.out_ir, held);
    end
    set_in(1'b1, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL drain c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      if (i < 4) begin
        n_vec++;
        if (bus.out_pc !== 10'(i)) begin
          n_err++;
          $display("FAIL drain_order c%0d got %0d want %0d", i, bus.out_pc, i);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(1'b1, 1'b0, i == 7, 10'd200);
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL redir c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      n_vec++;
      if (i == 7 && {bus.out_valid, bus.out_pc} !== {1'b1, 10'd5}) begin
        n_err++;
        $display("FAIL redir_head got v%b pc%0d want 1 5",
                 bus.out_valid, bus.out_pc);
      end else if ((i == 8 || i == 9) && bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL redir_bubble c%0d got %b want 0", i, bus.out_valid);
      end else if (i >= 10 && bus.out_pc !== 10'(190 + i)) begin
        n_err++;
        $display("FAIL redir_target c%0d got %0d want %0d",
                 i, bus.out_pc, 190 + i);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, i >= 12 && i < 17, 1'b0, 10'd0);
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL halt c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      n_vec++;
      if (i >= 12 && i < 17 && {bus.imem_rd_en, bus.imem_addr}
          !== {1'b0, 10'd12}) begin
        n_err++;
        $display("FAIL halt_hold c%0d got rd%b a%0d want 0 12",
                 i, bus.imem_rd_en, bus.imem_addr);
      end else if (i == 13 && bus.out_pc !== 10'd11) begin
        n_err++;
        $display("FAIL halt_inflight got %0d want 11", bus.out_pc);
      end else if (i == 17 && {bus.imem_rd_en, bus.imem_addr}
                   !== {1'b1, 10'd12}) begin
        n_err++;
        $display("FAIL halt_resume got rd%b a%0d want 1 12",
                 bus.imem_rd_en, bus.imem_addr);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [9:0] wpc [3];
    wpc[0] = 10'd1022;
    wpc[1] = 10'd1023;
    wpc[2] = 10'd0;
    bus2.out_ready      = 1'b1;
    bus2.halt           = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 10'd0;
    rst2 = 1'b1;
    tick();
    tick();
    rst2 = 1'b0;
    #1;
    n_vec++;
    if ({bus2.imem_rd_en, bus2.imem_addr} !== {1'b1, 10'd1022}) begin
      n_err++;
      $display("FAIL wrap_start got rd%b a%0d want 1 1022",
               bus2.imem_rd_en, bus2.imem_addr);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({bus2.out_valid, bus2.out_pc, bus2.out_npc}
          !== {1'b1, wpc[i], wpc[i] + 10'd1}) begin
        n_err++;
        $display("FAIL wrap c%0d got v%b pc%0d npc%0d want 1 %0d %0d",
                 i, bus2.out_valid, bus2.out_pc, bus2.out_npc,
                 wpc[i], wpc[i] + 10'd1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_vec++;
    if ({bus.fifo_count, bus.imem_rd_en} !== {3'd3, 1'b0}) begin
      n_err++;
      $display("FAIL mid_pre got cnt%0d rd%b want 3 0",
               bus.fifo_count, bus.imem_rd_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL mid_rst c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      n_vec++;
      if (i == 0 && {bus.out_valid, bus.fifo_count, bus.imem_addr}
          !== {1'b0, 3'd0, 10'd0}) begin
        n_err++;
        $display("FAIL mid_clear got v%b cnt%0d a%0d want 0 0 0",
                 bus.out_valid, bus.fifo_count, bus.imem_addr);
      end else if (i == 2 && {bus.out_valid, bus.out_ir}
                   !== {1'b1, 32'h1000_0000}) begin
        n_err++;
        $display("FAIL mid_restart got v%b ir%h want 1 10000000",
                 bus.out_valid, bus.out_ir);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 700; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, 10'($urandom_range(0, 1023)));
      #1;
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random c%0d got %h want %h", i, act_vec(), exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    rst2  = 1'b1;
    m_pc  = 10'd0;
    m_fl  = 1'b0;
    m_fl_pc = 10'd0;
    set_in(1'b1, 1'b0, 1'b0, 10'd0);
    bus2.out_ready      = 1'b1;
    bus2.halt           = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 10'd0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
